muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Parametrised sequential M-extension unit: the next generation of the core's multiply/divide block.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
- Multiplier retires a configurable number of bits per cycle; divider is restoring, 1 bit/cycle.
- Sits in EX beside the ALU. Uses a valid/ready request handshake and a held result with backpressure. A flush aborts work on pipeline kill.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per compute cycle; must be 1, 2 or 4 and divide XLEN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  multiplicand/dividend
- rs2_i  in  XLEN  multiplier/divisor
- flush_i  in  1  abort current operation
- valid_o  out  1  result valid
- result_ready_i  in  1  consumer takes result
- result_o  out  XLEN  result
- busy_o  out  1  high in MUL, DIV or DONE

Behaviour:
- Reset (rst_i high at an edge): state IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, counters and datapath cleared. Reset has priority over everything, including mid-operation; no result appears afterwards.
- States: IDLE, MUL, DIV, DONE.
- ready_o=1 only in IDLE. valid_o=1 only in DONE.
- Accept: IDLE with valid_i=1 and flush_i=0 at an edge.
  - Latches op_i and operand magnitudes.
  - Sign handling follows the op: MUL/MULH sign both; MULHSU signs rs1 only; DIV/REM sign both; the others are unsigned.
  - Loads counter: N = XLEN/MUL_BITS_PER_CYCLE for multiply, N = XLEN for divide.
  - Next state is MUL or DIV.
- Compute: each edge in MUL or DIV performs one step and decrements the counter.
  - MUL step: add the partial product of the low MUL_BITS_PER_CYCLE multiplier bits into the 2*XLEN accumulator, then shift right by MUL_BITS_PER_CYCLE.
  - DIV step: shift remainder/quotient left by 1; subtract the divisor when non-negative and set the quotient bit.
- The step that takes the counter to 0 applies sign fixup:
  - product negated if operand signs differ;
  - quotient negated if signs differ;
  - remainder takes the dividend's sign.
- That step registers result_o and moves to DONE. valid_o therefore rises N edges after the accept edge.
- Result select:
  - MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2*XLEN-1:XLEN].
  - DIV/DIVU give the quotient; REM/REMU give the remainder.
- Divide by zero: quotient all-ones, remainder = rs1 (signed and unsigned).
- Signed overflow (rs1 = most-negative, rs2 = -1): DIV gives the most-negative value, REM gives 0.
- DONE: valid_o and result_o are held stable until result_ready_i=1 at an edge, then the unit returns to IDLE. No back-to-back accept from DONE; the next request is accepted from IDLE at the earliest one cycle later.
- Flush: flush_i=1 at an edge in MUL, DIV or DONE moves the unit to IDLE; valid_o=0 next cycle and the result is discarded.
  - flush_i together with valid_i in IDLE: the request is not accepted.
  - flush_i together with result_ready_i in DONE: the unit goes to IDLE, with the same outcome.
- Inputs are sampled only on the accept edge; later changes to rs1_i, rs2_i or op_i are ignored.

Optional Feature:
- Macro: MULDIV_SEQ_DIV_SHORTCUT_EN
- Defined: divide-by-zero and signed-overflow requests skip the DIV state. The accept edge registers the special result and enters DONE, so valid_o is high one cycle after accept.
- Undefined: these cases run the full XLEN compute cycles. Results are identical either way; only latency differs.

Test Plan:
(All tests use XLEN=32 and MUL_BITS_PER_CYCLE=2, so multiply N=16 and divide N=32.)
1. Multiply, rs1=0xFFFFFFFF, rs2=0x00000003:
   - MUL -> 0xFFFFFFFD; MULH -> 0xFFFFFFFF; MULHU -> 0x00000002; MULHSU -> 0xFFFFFFFF.
   - valid_o rises exactly 16 cycles after accept each time.
2. Divide, rs1=0xFFFFFFF9 (-7), rs2=0x00000002:
   - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
   - valid_o rises 32 cycles after accept.
3. Divide by zero, rs1=0x00000005, rs2=0:
   - DIVU -> 0xFFFFFFFF; REMU -> 0x00000005; DIV -> 0xFFFFFFFF; REM -> 0x00000005.
   - Latency is 32 cycles without the macro and 1 cycle with it.
4. Signed overflow, rs1=0x80000000, rs2=0xFFFFFFFF:
   - DIV -> 0x80000000; REM -> 0x00000000.
   - Same latency rule as test 3.
5. Flush during DIV: assert flush_i 5 cycles after accept.
   - Unit returns to IDLE next edge; valid_o never rises; ready_o=1.
   - A following MUL 7*6 returns 0x0000002A.
6. Backpressure and reset:
   - Hold result_ready_i=0 for 10 cycles in DONE: valid_o and result_o are stable, and valid_i is ignored.
   - Assert rst_i mid-MUL: all outputs take their reset values next cycle, with no stale result.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential M-extension multiply/divide unit: radix-2^MUL_BITS_PER_CYCLE shift-add multiplier, restoring divider.
// Optional MULDIV_SEQ_DIV_SHORTCUT_EN: divide-by-zero and signed overflow finish on the accept edge.
module muldiv_seq #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned B     = MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(XLEN / B);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   divisor_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;

  // Request decode
  logic            accept;
  logic            is_div;
  logic            sgn1, sgn2;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero;
  logic            shortcut;

  assign accept   = (state_q == S_IDLE) && valid_i && !flush_i;
  assign is_div   = op_i[2];
  assign sgn1     = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign sgn2     = is_div ? ~op_i[0] : ~op_i[1];
  assign neg1     = sgn1 & rs1_i[XLEN-1];
  assign neg2     = sgn2 & rs2_i[XLEN-1];
  assign mag1     = neg1 ? -rs1_i : rs1_i;
  assign mag2     = neg2 ? -rs2_i : rs2_i;
  assign div_zero = (rs2_i == '0);

`ifdef MULDIV_SEQ_DIV_SHORTCUT_EN
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign div_ovf     = ~op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign shortcut    = is_div && (div_zero || div_ovf);
  assign special_res = op_i[1] ? (div_zero ? rs1_i : '0)
                               : (div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`else
  assign shortcut = 1'b0;
`endif

  // Multiply step: add partial product into the upper half, shift whole accumulator right by B
  logic [XLEN+B-1:0] pp;
  logic [XLEN+B-1:0] hi_sum;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;

  assign pp       = {{B{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[B-1:0]};
  assign hi_sum   = {{B{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
  assign acc_step = {hi_sum, acc_q[XLEN-1:B]};
  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  // Restoring divide step
  logic [XLEN:0]   r_sh;
  logic [XLEN+1:0] diff;
  logic            nonneg;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;
  logic            unused_diff_bit;

  assign r_sh            = {rem_q, quo_q[XLEN-1]};
  assign diff            = {1'b0, r_sh} - {2'b00, divisor_q};
  assign nonneg          = ~diff[XLEN+1];
  assign rem_step        = nonneg ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign quo_step        = {quo_q[XLEN-2:0], nonneg};
  assign quo_fix         = neg_q ? -quo_step : quo_step;
  assign rem_fix         = rem_neg_q ? -rem_step : rem_step;
  assign div_res         = op_q[1] ? rem_fix : quo_fix;
  assign unused_diff_bit = diff[XLEN];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_div)       state_d = S_MUL;
          else if (shortcut) state_d = S_DONE;
          else               state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i)                      state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = S_DONE;
      end
      S_DONE: begin
        if (flush_i || result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op_i;
            rem_neg_q <= neg1;
            // Divide-by-zero keeps the all-ones quotient unsigned-looking
            neg_q     <= (neg1 ^ neg2) && !(is_div && div_zero);
            if (is_div) begin
              cnt_q     <= DIV_N;
              quo_q     <= mag1;
              rem_q     <= '0;
              divisor_q <= mag2;
            end else begin
              cnt_q   <= MUL_N;
              mcand_q <= mag1;
              acc_q   <= {{XLEN{1'b0}}, mag2};
            end
`ifdef MULDIV_SEQ_DIV_SHORTCUT_EN
            if (shortcut) result_q <= special_res;
`endif
          end
        end
        S_MUL: begin
          if (!flush_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) result_q <= mul_res;
          end
        end
        S_DIV: begin
          if (!flush_i) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) result_q <= div_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign busy_o   = (state_q != S_IDLE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (XLEN=32, 2 multiplier bits per cycle).
// Honours MULDIV_SEQ_DIV_SHORTCUT_EN for the expected special-case divide latency.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  muldiv_seq #(
    .XLEN               (32),
    .MUL_BITS_PER_CYCLE (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam int MUL_LAT = 16;
  localparam int DIV_LAT = 32;
  // Latency counts edges after the accept edge at which valid_o is first seen
`ifdef MULDIV_SEQ_DIV_SHORTCUT_EN
  localparam int SPC_LAT = 0;
`else
  localparam int SPC_LAT = 32;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i    = 3'd5;
    rs1_i   = 32'hDEAD_BEEF;
    rs2_i   = 32'h0000_1234;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    result_ready_i = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] held;

    vecs[0]  = '{MUL,    32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, MUL_LAT};
    vecs[1]  = '{MULH,   32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, MUL_LAT};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF, 32'h00000003, 32'h00000002, MUL_LAT};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT};
    vecs[5]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
    vecs[6]  = '{DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT};
    vecs[7]  = '{REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, DIV_LAT};
    vecs[8]  = '{DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC_LAT};
    vecs[9]  = '{REMU,   32'h00000005, 32'h00000000, 32'h00000005, SPC_LAT};
    vecs[10] = '{DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC_LAT};
    vecs[11] = '{REM,    32'h00000005, 32'h00000000, 32'h00000005, SPC_LAT};
    vecs[12] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT};
    vecs[13] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT};

    rst_i = 1'b1; valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    flush_i = 1'b0; result_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready_o",  {31'b0, ready_o}, 32'd1);
    check("reset valid_o",  {31'b0, valid_o}, 32'd0);
    check("reset busy_o",   {31'b0, busy_o},  32'd0);
    check("reset result_o", result_o,         32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d result", i), result_o, vecs[i].exp);
      release_result();
      check($sformatf("vec%0d idle after take", i), {31'b0, ready_o}, 32'd1);
    end

    // Flush in IDLE alongside a request: nothing accepted
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = MUL; rs1_i = 32'd2; rs2_i = 32'd2;
    @(posedge clk);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush+valid idle busy_o", {31'b0, busy_o}, 32'd0);

    // Flush five edges into a divide
    issue(DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush ready_o", {31'b0, ready_o}, 32'd1);
    check("flush valid_o", {31'b0, valid_o}, 32'd0);
    check("flush busy_o",  {31'b0, busy_o},  32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("flush no late valid", seen, 32'd0);
    issue(MUL, 32'd7, 32'd6);
    wait_valid(lat);
    check("post-flush mul latency", lat, MUL_LAT);
    check("post-flush mul result", result_o, 32'h0000002A);
    release_result();

    // Backpressure: DONE holds for 10 cycles while a new request is offered
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    check("bp latency", lat, MUL_LAT);
    held = 32'hFFFFFFFE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid_i = 1'b1; op_i = MUL; rs1_i = 32'd3; rs2_i = 32'd3;
      @(posedge clk);
      #1;
      check($sformatf("bp valid_o c%0d", c), {31'b0, valid_o}, 32'd1);
      check($sformatf("bp result_o c%0d", c), result_o, held);
      check($sformatf("bp ready_o c%0d", c), {31'b0, ready_o}, 32'd0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    release_result();
    check("bp idle ready_o", {31'b0, ready_o}, 32'd1);
    check("bp idle busy_o",  {31'b0, busy_o},  32'd0);
    issue(MUL, 32'd3, 32'd3);
    wait_valid(lat);
    check("bp next result", result_o, 32'd9);
    release_result();

    // Flush together with result_ready in DONE
    issue(MUL, 32'd5, 32'd5);
    wait_valid(lat);
    @(negedge clk);
    flush_i = 1'b1; result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; result_ready_i = 1'b0;
    check("done flush+take ready_o", {31'b0, ready_o}, 32'd1);
    check("done flush+take valid_o", {31'b0, valid_o}, 32'd0);

    // Reset mid-multiply
    issue(MUL, 32'h00001234, 32'h00000010);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ready_o",  {31'b0, ready_o}, 32'd1);
    check("midrst valid_o",  {31'b0, valid_o}, 32'd0);
    check("midrst busy_o",   {31'b0, busy_o},  32'd0);
    check("midrst result_o", result_o,         32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("midrst no stale valid", seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
